// File: rtl/status_led_sequencer_if.sv
// Front-panel LED bundle: startup-controller mode code and core strobes in,
// four active-low LED drives out.
interface status_led_sequencer_if;
  logic [2:0] MODE;
  logic       nACC_IN;
  logic       nDELAYING_IN;
  logic       nLED_ACC;
  logic       nLED_DELAYING;
  logic       nLED_STANDBY;
  logic       nLED_PWROK;

  modport master (
    output MODE, nACC_IN, nDELAYING_IN,
    input  nLED_ACC, nLED_DELAYING, nLED_STANDBY, nLED_PWROK
  );

  modport slave (
    input  MODE, nACC_IN, nDELAYING_IN,
    output nLED_ACC, nLED_DELAYING, nLED_STANDBY, nLED_PWROK
  );
endinterface

// File: rtl/status_led_sequencer.sv
// Registered front-panel LED driver: mode-specific blink patterns on a 1 ms
// tick plus a pulse stretcher so short access strobes stay visible.
module status_led_sequencer #(
  parameter int unsigned CLK_HZ         = 48000000,
  parameter int unsigned BLINK_SLOW_MS  = 500,
  parameter int unsigned BLINK_FAST_MS  = 125,
  parameter int unsigned ACC_STRETCH_MS = 30
) (
  input logic                   MCLK,
  input logic                   MRST,
  status_led_sequencer_if.slave bus
);

  localparam int unsigned TICK_CYC  = CLK_HZ / 1000;
  localparam int unsigned PW        = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;
  localparam int unsigned BLINK_MAX = (BLINK_SLOW_MS > BLINK_FAST_MS) ? BLINK_SLOW_MS : BLINK_FAST_MS;
  localparam int unsigned BW        = (BLINK_MAX > 1) ? $clog2(BLINK_MAX) : 1;
  localparam int unsigned SW        = $clog2(ACC_STRETCH_MS + 1);

  localparam logic [2:0] M_EMU0 = 3'b010;
  localparam logic [2:0] M_EMU1 = 3'b011;
  localparam logic [2:0] M_STBY = 3'b101;
  localparam logic [2:0] M_ERR0 = 3'b110;
  localparam logic [2:0] M_ERR1 = 3'b111;

  logic [PW-1:0] presc_q, presc_d;
  logic [BW-1:0] blink_q, blink_d;
  logic [SW-1:0] stretch_q, stretch_d;
  logic          phase_q, phase_d;     // 1 = ON half-period
  logic [2:0]    mode_q, mode_d;
  logic [3:0]    led_q, led_d;         // {ACC, DELAYING, STANDBY, PWROK}, active-low

  logic          tick;
  logic          acc_on;
  logic [BW-1:0] blink_lim;

  always_comb begin
    tick      = (presc_q == PW'(TICK_CYC - 1));
    blink_lim = (mode_q == M_ERR0 || mode_q == M_ERR1) ? BW'(BLINK_FAST_MS - 1)
                                                       : BW'(BLINK_SLOW_MS - 1);
    presc_d   = tick ? '0 : presc_q + PW'(1);
    blink_d   = blink_q;
    phase_d   = phase_q;
    mode_d    = mode_q;

    if (tick) begin
      if (blink_q == blink_lim) begin
        blink_d = '0;
        phase_d = ~phase_q;
      end else begin
        blink_d = blink_q + BW'(1);
      end
    end

    // A mode change overrides any tick in the same cycle so the new pattern
    // opens with a full ON half-period.
    if (bus.MODE != mode_q) begin
      presc_d = '0;
      blink_d = '0;
      phase_d = 1'b1;
      mode_d  = bus.MODE;
    end

    if (!bus.nACC_IN)
      stretch_d = SW'(ACC_STRETCH_MS);
    else if (tick && stretch_q != '0)
      stretch_d = stretch_q - SW'(1);
    else
      stretch_d = stretch_q;

    acc_on = !bus.nACC_IN || (stretch_q != '0);

    led_d = '1;
    case (mode_d)
      M_EMU0, M_EMU1: begin
        led_d[0] = 1'b0;
        led_d[2] = bus.nDELAYING_IN;
        led_d[3] = ~acc_on;
      end
      M_STBY: begin
        led_d[0] = 1'b0;
        led_d[1] = ~phase_d;
      end
      M_ERR0: led_d[0] = ~phase_d;
      M_ERR1: begin
        led_d[0] = ~phase_d;
        led_d[1] = phase_d;
      end
      default: led_d = '1;
    endcase
  end

  always_ff @(posedge MCLK) begin
    if (MRST) begin
      presc_q   <= '0;
      blink_q   <= '0;
      stretch_q <= '0;
      phase_q   <= 1'b1;
      mode_q    <= '0;
      led_q     <= '1;
    end else begin
      presc_q   <= presc_d;
      blink_q   <= blink_d;
      stretch_q <= stretch_d;
      phase_q   <= phase_d;
      mode_q    <= mode_d;
      led_q     <= led_d;
    end
  end

  assign bus.nLED_ACC      = led_q[3];
  assign bus.nLED_DELAYING = led_q[2];
  assign bus.nLED_STANDBY  = led_q[1];
  assign bus.nLED_PWROK    = led_q[0];

endmodule

// File: tb/tb_status_led_sequencer.sv
// Directed bench for status_led_sequencer with a 8-cycle ms tick,
// 4/2 ms blink half-periods and a 3 ms access stretch.
module tb_status_led_sequencer;

  logic MCLK;
  logic MRST;
  status_led_sequencer_if bus ();

  status_led_sequencer #(
    .CLK_HZ         (8000),
    .BLINK_SLOW_MS  (4),
    .BLINK_FAST_MS  (2),
    .ACC_STRETCH_MS (3)
  ) dut (
    .MCLK (MCLK),
    .MRST (MRST),
    .bus  (bus)
  );

  int unsigned errors = 0;
  int unsigned checks = 0;
  logic [3:0]  leds;   // {ACC, DELAYING, STANDBY, PWROK}

  assign leds = {bus.nLED_ACC, bus.nLED_DELAYING, bus.nLED_STANDBY, bus.nLED_PWROK};

  initial MCLK = 1'b0;
  always #5 MCLK = ~MCLK;

  task automatic step();
    @(posedge MCLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_range(input string tag, input int obs, input int lo, input int hi);
    checks++;
    assert (obs >= lo && obs <= hi) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    logic p;
    logic d;

    // Reset held with emulator mode and access asserted.
    MRST = 1'b1;
    bus.MODE = 3'b011;
    bus.nACC_IN = 1'b0;
    bus.nDELAYING_IN = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("reset_hold", leds, 4'b1111);
    end
    MRST = 1'b0;
    step();
    check("reset_release", leds, 4'b0110);

    // Stretch after a long access strobe ends.
    bus.nACC_IN = 1'b1;
    n = 0;
    while (leds[3] == 1'b0 && n < 40) begin
      step();
      n++;
    end
    check_range("acc_release_on_len", n - 1, 17, 24);

    // Single-cycle strobe, then retrigger 10 cycles later.
    bus.nACC_IN = 1'b0;
    step();
    check("acc_strobe1", leds, 4'b0110);
    bus.nACC_IN = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      check("acc_stretch_hold", leds, 4'b0110);
    end
    bus.nACC_IN = 1'b0;
    step();
    check("acc_strobe2", leds, 4'b0110);
    bus.nACC_IN = 1'b1;
    n = 0;
    while (leds[3] == 1'b0 && n < 40) begin
      step();
      n++;
    end
    check_range("acc_retrig_on_len", n - 1, 17, 24);

    // MPSSE standby: slow blink, ACC and DELAYING suppressed.
    bus.MODE = 3'b101;
    bus.nACC_IN = 1'b0;
    bus.nDELAYING_IN = 1'b0;
    for (int i = 0; i < 96; i++) begin
      step();
      p = ((i / 32) % 2) != 0;
      check("mpsse_blink", leds, {1'b1, 1'b1, p, 1'b0});
    end

    // ERROR_S1: fast anti-phase blink, DELAYING ignored.
    bus.MODE = 3'b111;
    for (int i = 0; i < 64; i++) begin
      bus.nDELAYING_IN = (i % 2) != 0;
      step();
      p = ((i / 16) % 2) != 0;
      check("err1_blink", leds, {1'b1, 1'b1, ~p, p});
    end

    // ERROR_S0, then switch to standby 10 cycles into the OFF half-period.
    bus.MODE = 3'b110;
    for (int i = 0; i < 27; i++) begin
      step();
      p = ((i / 16) % 2) != 0;
      check("err0_blink", leds, {1'b1, 1'b1, 1'b1, p});
    end
    bus.MODE = 3'b101;
    for (int j = 0; j < 33; j++) begin
      step();
      check("midblink_switch", leds, {1'b1, 1'b1, (j >= 32), 1'b0});
    end

    // Emulator: DELAYING passthrough with one cycle of latency.
    bus.MODE = 3'b010;
    for (int k = 0; k < 30; k++) begin
      d = ((k / 5) % 2) != 0;
      bus.nDELAYING_IN = d;
      step();
      check("delay_pass", leds, {1'b0, d, 1'b1, 1'b0});
    end

    // RESET mode code: everything dark, even with access asserted.
    bus.MODE = 3'b000;
    for (int i = 0; i < 3; i++) begin
      step();
      check("mode_reset_dark", leds, 4'b1111);
    end

    // Reset during an active stretch clears it.
    bus.MODE = 3'b011;
    bus.nDELAYING_IN = 1'b1;
    step();
    check("pre_abort_on", leds, 4'b0110);
    bus.nACC_IN = 1'b1;
    step();
    check("pre_abort_stretch", leds, 4'b0110);
    MRST = 1'b1;
    step();
    check("abort_reset", leds, 4'b1111);
    MRST = 1'b0;
    step();
    check("abort_release", leds, 4'b1110);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/status_led_sequencer.md
Name: status_led_sequencer

Overview:
- Drives the four front-panel LEDs (ACC, DELAYING, STANDBY, PWROK) from the startup-control state code and the core status strobes.
- Sits directly downstream of the top-level startup controller. It replaces the free-running 1 s blinker and the ad-hoc LED gating with one registered block.
- Adds mode-specific blink patterns and an access-LED pulse stretcher so that short nACC strobes from the emulator core are visible.

Parameters:
- CLK_HZ, 48000000: MCLK frequency. The 1 ms tick period is CLK_HZ/1000 cycles; CLK_HZ must be a multiple of 1000.
- BLINK_SLOW_MS, 500: half-period of the slow blink, in ms.
- BLINK_FAST_MS, 125: half-period of the fast blink, in ms.
- ACC_STRETCH_MS, 30: minimum visible on-time of the ACC LED, in ms (≥1).

Ports:
- MCLK  in  1  system clock
- MRST  in  1  synchronous reset, active-high
- MODE  in  3  startup-controller state code: 000 RESET, 001 MODE_SELECT, 010/011 EMULATOR, 101 MPSSE_STANDBY, 110 ERROR_S0, 111 ERROR_S1, 100 unused
- nACC_IN  in  1  access strobe from the emulator core, active-low, any width ≥1 cycle
- nDELAYING_IN  in  1  delaying indication from the temperature core, active-low
- nLED_ACC  out  1  access LED, active-low
- nLED_DELAYING  out  1  delaying LED, active-low
- nLED_STANDBY  out  1  standby LED, active-low
- nLED_PWROK  out  1  power-OK LED, active-low

Behaviour:
- All outputs are registered with 1-cycle latency from inputs, except that blink phase advances only on ms ticks.
- Reset (MRST=1 at an MCLK edge):
  - All four nLED_* go to 1 (off).
  - Tick prescaler, blink counter and stretch counter go to 0; blink phase = ON; mode_q = 000.
  - Reset asserted mid-blink or mid-stretch aborts immediately.
- Tick prescaler:
  - Counts 0..CLK_HZ/1000-1; tick=1 for one cycle when it wraps.
  - Blink counter counts ticks. At BLINK_x_MS-1 it clears and toggles the phase. x is SLOW or FAST, selected by the current mode.
- Mode change (MODE ≠ mode_q):
  - Prescaler and blink counter clear, phase = ON, mode_q ← MODE in the same cycle.
  - The new pattern therefore starts with a full ON half-period.
  - The ACC stretch counter is unaffected.
- Patterns (ON means the LED output is 0):
  - 000, 001, 100: all LEDs off, ACC included; the stretch counter still runs.
  - 010, 011 (emulator):
    - PWROK solid on; STANDBY off.
    - DELAYING follows nDELAYING_IN (registered).
    - ACC is stretched (see below).
  - 101 (MPSSE standby): PWROK solid on; STANDBY blinks slow; DELAYING off; ACC off.
  - 110 (ERROR_S0): PWROK blinks fast; all others off.
  - 111 (ERROR_S1): PWROK and STANDBY blink fast in anti-phase (PWROK on when phase = ON); DELAYING and ACC off.
- ACC stretcher:
  - While nACC_IN=0, the stretch counter loads ACC_STRETCH_MS every cycle.
  - While nACC_IN=1, the counter decrements on each tick and saturates at 0.
  - acc_on = (nACC_IN==0) | (counter≠0).
  - nLED_ACC = ~acc_on in emulator modes, otherwise 1.
  - After nACC_IN rises, the LED stays on for more than (ACC_STRETCH_MS-1) ms and at most ACC_STRETCH_MS ms.
  - Retriggering during the stretch reloads the counter; there is no gap.
- Simultaneous events:
  - A mode change and a tick in the same cycle: the mode-change clear wins.
  - nACC_IN low and a tick in the same cycle: the load wins.
- Inputs are synchronous to MCLK. The block does no synchronization.

Test Plan:
(Bench parameters: CLK_HZ=8000, so a tick every 8 cycles; BLINK_SLOW_MS=4; BLINK_FAST_MS=2; ACC_STRETCH_MS=3.)
1. Reset: hold MRST 3 cycles with MODE=011 and nACC_IN=0 → all nLED_*=1 during reset and on the first edge after. Release MRST → next cycle nLED_PWROK=0 and nLED_ACC=0.
2. Emulator stretch: MODE=011, nACC_IN low 1 cycle → nLED_ACC=0 next cycle and stays 0 for 17–24 cycles after nACC_IN rises. A second 1-cycle strobe 10 cycles later extends the on-time with no 1-glitch.
3. MPSSE blink: MODE 011→101 → nLED_STANDBY=0 for 32 cycles, then 1 for 32 cycles, repeating. nLED_PWROK stays 0. nLED_ACC stays 1 even with nACC_IN=0.
4. ERROR_S1: MODE=111 → PWROK and STANDBY toggle every 16 cycles, always complementary. nLED_DELAYING=1 regardless of nDELAYING_IN.
5. Mode change mid-blink: in MODE=110, change to 101 at cycle 10 of a PWROK OFF half-period → the next cycle starts STANDBY ON for a full 32 cycles, with PWROK solid 0.
6. Delaying passthrough: MODE=010, toggle nDELAYING_IN 0/1 every 5 cycles → nLED_DELAYING mirrors it with 1-cycle delay. Then MODE=000 → all LEDs 1.
